// File: rtl/sorter_pkg.sv
// Shared types and helpers for the package sorter/diverter pipeline.
// Optional jam freeze is enabled by defining DIVERTER_JAM_EN.
package sorter_pkg;

   localparam int NUM_GRPS = 6;
   localparam int CNT_W    = 8;

   localparam logic [2:0] GRP_NONE = 3'd0;
   localparam logic [2:0] GRP1     = 3'd1;
   localparam logic [2:0] GRP2     = 3'd2;
   localparam logic [2:0] GRP3     = 3'd3;
   localparam logic [2:0] GRP4     = 3'd4;
   localparam logic [2:0] GRP5     = 3'd5;
   localparam logic [2:0] GRP6     = 3'd6;

   typedef struct packed {
      logic             valid;
      logic [2:0]       grp;
      logic [CNT_W-1:0] cnt;
   } slot_t;

   function automatic int grp_distance(
      input int g,
      input int travel,
      input int pitch
   );
      return travel + (g - 1) * pitch;
   endfunction

endpackage

// File: rtl/gate_pulse_stretcher.sv
// Holds one diverter gate open for PULSE_CYCLES clocks per fire.
// With DIVERTER_JAM_EN, the freeze input holds the counter in place.
import sorter_pkg::*;

module gate_pulse_stretcher #(
   parameter int PULSE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
`ifdef DIVERTER_JAM_EN
   input  logic freeze,
`endif
   input  logic fire,
   output logic open
);

   localparam int PW = $clog2(PULSE_CYCLES + 1);

   logic [PW-1:0] r_cnt;
   logic          w_run;

`ifdef DIVERTER_JAM_EN
   assign w_run = !freeze;
`else
   assign w_run = 1'b1;
`endif

   // A refire reloads rather than queueing a second pulse.
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (fire) begin
         r_cnt <= PW'(PULSE_CYCLES);
      end else if (r_cnt != '0 && w_run) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign open = (r_cnt != '0);

endmodule

// File: rtl/package_diverter.sv
// Tracks sorted items along the belt and pulses each group's gate.
// Defining DIVERTER_JAM_EN adds a jam input that freezes the belt.
import sorter_pkg::*;

module package_diverter #(
   parameter int DEPTH        = 4,
   parameter int CNT_W        = sorter_pkg::CNT_W,
   parameter int TRAVEL_TICKS = 20,
   parameter int GATE_PITCH   = 10,
   parameter int PULSE_CYCLES = 4,
   localparam int OCC_W       = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       grp_in,
   input  logic             belt_tick,
`ifdef DIVERTER_JAM_EN
   input  logic             jam,
`endif
   output logic [5:0]       gate,
   output logic             busy,
   output logic [OCC_W-1:0] occupancy,
   output logic [7:0]       drop_count,
   output logic             overflow
);

   generate
      if (CNT_W != sorter_pkg::CNT_W ||
          grp_distance(NUM_GRPS, TRAVEL_TICKS, GATE_PITCH)
             >= (1 << CNT_W)) begin : g_bad_cfg
         $error("package_diverter: CNT_W too narrow");
      end
   endgenerate

   slot_t            r_slot [DEPTH];
   slot_t            w_slot [DEPTH];
   logic             r_prev_zero;
   logic             w_is_grp;
   logic             w_new;
   logic             w_tick;
   logic             w_taken;
   logic             w_drop;
   logic [CNT_W-1:0] w_dist;
   logic [5:0]       w_fire;
   logic [OCC_W-1:0] w_occ;

   assign w_is_grp = (grp_in != GRP_NONE) && (grp_in != 3'd7);
   assign w_new    = r_prev_zero && w_is_grp;
   assign w_dist   = CNT_W'(grp_distance(int'(grp_in),
                                         TRAVEL_TICKS,
                                         GATE_PITCH));

`ifdef DIVERTER_JAM_EN
   assign w_tick = belt_tick && !jam;
`else
   assign w_tick = belt_tick;
`endif

   // Allocation and expiry both read pre-edge slot state, so a
   // slot freed this edge only becomes allocatable next edge.
   always_comb begin
      w_taken = 1'b0;
      w_fire  = '0;
      w_occ   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_slot[i] = r_slot[i];
         if (w_new && !r_slot[i].valid && !w_taken) begin
            w_taken         = 1'b1;
            w_slot[i].valid = 1'b1;
            w_slot[i].grp   = grp_in;
            w_slot[i].cnt   = w_dist;
         end else if (r_slot[i].valid && w_tick) begin
            if (r_slot[i].cnt <= CNT_W'(1)) begin
               w_slot[i].valid = 1'b0;
               w_slot[i].cnt   = '0;
               for (int g = 0; g < NUM_GRPS; g++) begin
                  if (r_slot[i].grp == 3'(g + 1)) begin
                     w_fire[g] = 1'b1;
                  end
               end
            end else begin
               w_slot[i].cnt = r_slot[i].cnt - 1'b1;
            end
         end
         w_occ = w_occ + OCC_W'(w_slot[i].valid);
      end
      w_drop = w_new && !w_taken;
   end

   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_slot[i] <= '0;
         end
         r_prev_zero <= 1'b1;
         occupancy   <= '0;
         busy        <= 1'b0;
         drop_count  <= '0;
         overflow    <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            r_slot[i] <= w_slot[i];
         end
         r_prev_zero <= !w_is_grp;
         occupancy   <= w_occ;
         busy        <= (w_occ != '0);
         if (w_drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) begin
               drop_count <= drop_count + 8'd1;
            end
         end
      end
   end

   generate
      for (genvar g = 0; g < NUM_GRPS; g++) begin : g_gate
         gate_pulse_stretcher #(
            .PULSE_CYCLES(PULSE_CYCLES)
         ) u_pulse (
            .clk   (clk),
            .reset (reset),
`ifdef DIVERTER_JAM_EN
            .freeze(jam),
`endif
            .fire  (w_fire[g]),
            .open  (gate[g])
         );
      end
   endgenerate

endmodule

// File: tb/tb_package_diverter.sv
// Self-checking bench for package_diverter against an item-list model.
// Expiry is modelled as an absolute belt-tick due time per item.
module tb_package_diverter;

   localparam int DEPTH = 4;
   localparam int TT    = 20;
   localparam int GP    = 10;
   localparam int PC    = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] grp_in;
   logic       belt_tick;
   logic [5:0] gate;
   logic       busy;
   logic [2:0] occupancy;
   logic [7:0] drop_count;
   logic       overflow;
`ifdef DIVERTER_JAM_EN
   logic       jam = 1'b0;
`endif

   always #5 clk = ~clk;

   package_diverter dut (
      .clk       (clk),
      .reset     (reset),
      .grp_in    (grp_in),
      .belt_tick (belt_tick),
`ifdef DIVERTER_JAM_EN
      .jam       (jam),
`endif
      .gate      (gate),
      .busy      (busy),
      .occupancy (occupancy),
      .drop_count(drop_count),
      .overflow  (overflow)
   );

   typedef struct {
      int grp;
      int due;
   } item_t;

   item_t items[$];
   int    m_ticks;
   int    m_edge;
   int    m_open_until [6];
   int    m_drop;
   bit    m_ovf;
   bit    m_prev_zero;
   int    total = 0;
   int    bad = 0;
   int    hi_cnt;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("%s", tag);
      end
   endtask

   task automatic model_reset();
      items.delete();
      m_ticks = 0;
      m_edge = 0;
      foreach (m_open_until[g]) m_open_until[g] = 0;
      m_drop = 0;
      m_ovf = 1'b0;
      m_prev_zero = 1'b1;
   endtask

   task automatic model_edge(input int g, input bit tick);
      int pre;
      bit is_grp;
      bit nw;
      pre = items.size();
      is_grp = (g >= 1 && g <= 6);
      nw = m_prev_zero && is_grp;
      m_prev_zero = !is_grp;
      m_edge++;
      if (tick) begin
         m_ticks++;
         for (int i = items.size() - 1; i >= 0; i--) begin
            if (items[i].due == m_ticks) begin
               m_open_until[items[i].grp - 1] = m_edge + PC;
               items.delete(i);
            end
         end
      end
      if (nw) begin
         if (pre < DEPTH) begin
            items.push_back('{g, m_ticks + TT + (g - 1) * GP});
         end else begin
            if (m_drop < 255) m_drop++;
            m_ovf = 1'b1;
         end
      end
   endtask

   task automatic check_all(input string tag);
      logic [5:0] eg;
      for (int g = 0; g < 6; g++) eg[g] = (m_edge < m_open_until[g]);
      chk({tag, ".gate"}, 32'(gate), 32'(eg));
      chk({tag, ".occ"}, 32'(occupancy), 32'(items.size()));
      chk({tag, ".busy"}, 32'(busy), 32'(items.size() != 0));
      chk({tag, ".drop"}, 32'(drop_count), 32'(m_drop));
      chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
   endtask

   task automatic step(input string tag, input int g, input bit tick);
      grp_in = 3'(g);
      belt_tick = tick;
      @(negedge clk);
      model_edge(g, tick);
      #1;
      check_all(tag);
      if (gate[2]) hi_cnt++;
   endtask

   initial begin
      int g;
      int run;
      bit tk;
      reset = 1'b0;
      grp_in = 3'd0;
      belt_tick = 1'b0;
      model_reset();
      #12;
      check_all("rst");
      @(posedge clk);
      reset = 1'b1;

      // single item held on the scale for several cycles
      hi_cnt = 0;
      step("t1", 0, 1'b1);
      repeat (5) step("t1", 3, 1'b1);
      step("t1", 0, 1'b1);
      chk("t1.one_capture", 32'(occupancy), 32'd1);
      repeat (45) step("t1", 0, 1'b1);
      chk("t1.g3_width", 32'(hi_cnt), 32'(PC));

      // later group first, earlier group overtakes
      step("t2", 6, 1'b1);
      step("t2", 0, 1'b1);
      step("t2", 1, 1'b1);
      repeat (80) step("t2", 0, 1'b1);

      // fill the tracker without ticks, then overflow
      for (int k = 1; k <= 5; k++) begin
         step("t3", k, 1'b0);
         step("t3", 0, 1'b0);
      end
      chk("t3.occ_full", 32'(occupancy), 32'd4);
      chk("t3.drop1", 32'(drop_count), 32'd1);
      step("t3", 6, 1'b0);
      step("t3", 0, 1'b0);
      chk("t3.drop2", 32'(drop_count), 32'd2);
      chk("t3.ovf", 32'(overflow), 32'd1);

      // expiry and arrival on the same edge while full
      repeat (19) step("t4", 0, 1'b1);
      step("t4", 2, 1'b1);
      chk("t4.drop3", 32'(drop_count), 32'd3);
      chk("t4.occ3", 32'(occupancy), 32'd3);
      step("t4", 0, 1'b0);
      step("t4", 5, 1'b0);
      chk("t4.reuse", 32'(occupancy), 32'd4);
      step("t4", 0, 1'b0);
      repeat (80) step("t4", 0, 1'b1);

      // reset mid-flight with gate[1] open
      step("t5", 2, 1'b1);
      step("t5", 0, 1'b1);
      repeat (30) step("t5", 0, 1'b1);
      chk("t5.g2_open", 32'(gate[1]), 32'd1);
      grp_in = 3'd4;
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      chk("t5.gate0", 32'(gate), 32'd0);
      check_all("t5rst");
      @(posedge clk);
      reset = 1'b1;
      repeat (4) step("t5", 4, 1'b0);
      chk("t5.once", 32'(occupancy), 32'd1);
      step("t5", 0, 1'b0);

      // randomized traffic
      for (int n = 0; n < 150; n++) begin
         g = int'($urandom_range(0, 7));
         run = int'($urandom_range(1, 4));
         for (int r = 0; r < run; r++) begin
            tk = ($urandom_range(0, 3) != 0);
            step("rnd", g, tk);
         end
      end
      repeat (90) step("drain", 0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
